// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle CPU control path: opcodes, FSM state
// encoding, ALUop codes and datapath select codes.
package mcpu_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JAL    = 4'd12
   } state_t;

   // ALUop must match the ALU controller's decoding exactly
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_RD = 2'd1;
   localparam logic [1:0] RDST_RA = 2'd2;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic op_known(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational state -> control word decoder (Moore part of the controller).
module mcc_output_decode
   import mcpu_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   // Unlisted fields stay 0; unused codes 13-15 produce an all-zero word
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCS_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RT;
            ctrl.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RD;
            ctrl.mem_to_reg = M2R_ALUOUT;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_JUMP;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RT;
            ctrl.mem_to_reg = M2R_ALUOUT;
         end
         // PC already holds PC+4 here, so it is the link value for $31
         S_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RA;
            ctrl.mem_to_reg = M2R_PC;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCS_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU main control FSM: state register, opcode dispatch,
// memory-ready stalls and reset gating of all write enables.
module multi_cycle_controller
   import mcpu_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] op_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       IorD_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic [1:0] MemtoReg_o,
   output logic [1:0] RegDst_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUop_o,
   output logic [1:0] PCSource_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   state_t state, state_nxt;
   ctrl_t  cw, cw_out;

   mcc_output_decode u_dec (
      .state (state),
      .ctrl  (cw)
   );

   // State register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= S_FETCH;
      else        state <= state_nxt;
   end

   // Next-state: dispatch in DECODE, stall in memory states until ready
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op_i)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_R:         state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               OP_JAL:       state_nxt = S_JAL;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: state_nxt = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_nxt = mem_ready_i ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_nxt = mem_ready_i ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nxt = S_RWB;
         S_ADDIEX: state_nxt = S_ADDIWB;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // Hold IR/PC in FETCH until memory delivers; in reset show FETCH selects
   // with every enable and request forced low (aborts writes immediately)
   always_comb begin
      cw_out = cw;
      if (state == S_FETCH && !mem_ready_i) begin
         cw_out.ir_write = 1'b0;
         cw_out.pc_write = 1'b0;
      end
      if (!rst_i) begin
         cw_out           = '0;
         cw_out.alu_src_b = SRCB_FOUR;
      end
   end

   assign illegal_o     = rst_i && (state == S_DECODE) && !op_known(op_i);
   assign state_o       = rst_i ? state : S_FETCH;
   assign PCWrite_o     = cw_out.pc_write;
   assign PCWriteCond_o = cw_out.pc_write_cond;
   assign IorD_o        = cw_out.iord;
   assign MemRead_o     = cw_out.mem_read;
   assign MemWrite_o    = cw_out.mem_write;
   assign IRWrite_o     = cw_out.ir_write;
   assign MemtoReg_o    = cw_out.mem_to_reg;
   assign RegDst_o      = cw_out.reg_dst;
   assign RegWrite_o    = cw_out.reg_write;
   assign ALUSrcA_o     = cw_out.alu_src_a;
   assign ALUSrcB_o     = cw_out.alu_src_b;
   assign ALUop_o       = cw_out.alu_op;
   assign PCSource_o    = cw_out.pc_source;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: each cycle pushes the expected
// output word to a scoreboard and pops/compares it before the next edge.
module tb_multi_cycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       ill, pcw, pcwc, iord, mr, mw, irw;
      logic [1:0] m2r, rdst;
      logic       rw, sa;
      logic [1:0] sb, aop, pcs;
   } obs_t;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                          JAL = 6'b000011, BAD = 6'b111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] op = 6'd0;
   logic       rdy = 1'b1;
   logic       pcw, pcwc, iord, mr, mw, irw, rw, sa, ill;
   logic [1:0] m2r, rdst, sb, aop, pcs;
   logic [3:0] st;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   step    = 0;
   obs_t sb_q[$];

   always #5 clk = ~clk;

   multi_cycle_controller dut (
      .clk_i(clk), .rst_i(rst), .op_i(op), .mem_ready_i(rdy),
      .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord),
      .MemRead_o(mr), .MemWrite_o(mw), .IRWrite_o(irw),
      .MemtoReg_o(m2r), .RegDst_o(rdst), .RegWrite_o(rw),
      .ALUSrcA_o(sa), .ALUSrcB_o(sb), .ALUop_o(aop), .PCSource_o(pcs),
      .illegal_o(ill), .state_o(st)
   );

   // Expected outputs taken straight from the state table
   function automatic obs_t expect_word(input int s, input logic r, input logic rs,
                                        input logic il);
      obs_t o = '0;
      o.st = 4'(s);
      case (s)
         0:  begin o.mr = 1; o.sb = 2'd1; o.irw = r; o.pcw = r; end
         1:  begin o.sb = 2'd3; o.ill = il; end
         2:  begin o.sa = 1; o.sb = 2'd2; end
         3:  begin o.mr = 1; o.iord = 1; end
         4:  begin o.rw = 1; o.m2r = 2'd1; end
         5:  begin o.mw = 1; o.iord = 1; end
         6:  begin o.sa = 1; o.aop = 2'b10; end
         7:  begin o.rw = 1; o.rdst = 2'd1; end
         8:  begin o.sa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'd1; end
         9:  begin o.pcw = 1; o.pcs = 2'd2; end
         10: begin o.sa = 1; o.sb = 2'd2; end
         11: begin o.rw = 1; end
         12: begin o.rw = 1; o.rdst = 2'd2; o.m2r = 2'd2; o.pcw = 1; o.pcs = 2'd2; end
         default: ;
      endcase
      if (!rs) begin
         o    = '0;
         o.sb = 2'd1;
      end
      return o;
   endfunction

   // One cycle: drive at negedge, push expectation, compare 4 ns later
   task automatic cyc(input logic [5:0] o, input logic r, input logic rs,
                      input int s, input logic il = 1'b0);
      obs_t got, exp;
      op  = o;
      rdy = r;
      rst = rs;
      sb_q.push_back(expect_word(s, r, rs, il));
      #4;
      got = '{st, ill, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, pcs};
      exp = sb_q.pop_front();
      n_tests++;
      step++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL step%0d state%0d observed=%h expected=%h", step, s, got, exp);
      end
      #6;
   endtask

   initial begin
      // reset held: FETCH selects, no enables
      cyc(R, 1, 0, 0);
      cyc(R, 1, 0, 0);
      // R-type: 0,1,6,7
      cyc(R, 1, 1, 0);  cyc(R, 1, 1, 1);  cyc(R, 1, 1, 6);  cyc(R, 1, 1, 7);
      // LW with two wait cycles in MEMRD
      cyc(LW, 1, 1, 0); cyc(LW, 1, 1, 1); cyc(LW, 1, 1, 2);
      cyc(LW, 0, 1, 3); cyc(LW, 0, 1, 3); cyc(LW, 1, 1, 3); cyc(LW, 1, 1, 4);
      // BEQ, J, ADDI, JAL
      cyc(BEQ, 1, 1, 0);  cyc(BEQ, 1, 1, 1);  cyc(BEQ, 1, 1, 8);
      cyc(J, 1, 1, 0);    cyc(J, 1, 1, 1);    cyc(J, 1, 1, 9);
      cyc(ADDI, 1, 1, 0); cyc(ADDI, 1, 1, 1); cyc(ADDI, 1, 1, 10); cyc(ADDI, 1, 1, 11);
      cyc(JAL, 1, 1, 0);  cyc(JAL, 1, 1, 1);  cyc(JAL, 1, 1, 12);
      // illegal opcode: one-cycle pulse in DECODE, then FETCH
      cyc(BAD, 1, 1, 0);  cyc(BAD, 1, 1, 1, 1'b1);
      // FETCH stall then SW, reset asserted while waiting in MEMWR
      cyc(SW, 0, 1, 0);   cyc(SW, 1, 1, 0);   cyc(SW, 1, 1, 1);   cyc(SW, 1, 1, 2);
      cyc(SW, 0, 1, 5);   cyc(SW, 0, 1, 5);   cyc(SW, 0, 0, 5);
      // after release: FETCH resumes
      cyc(SW, 1, 1, 0);   cyc(SW, 1, 1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
